// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with pending-write scoreboard and post-reset clear sweep; optional REG_FILE_SB_BYPASS_EN forwarding
module reg_file_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_addr,
  output logic             busy1,
  output logic             busy2,
  output logic             ready
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [AW-1:0]     ptr, ptr_nxt;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              run, wr_ok, iss_ok;

  assign run    = (state == S_RUN);
  assign wr_ok  = run && we && !(ZERO_REG != 0 && wa == '0);
  assign iss_ok = run && iss_valid && !(ZERO_REG != 0 && iss_addr == '0);
  assign ready  = run;

  // State and sweep pointer register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Sweep walks every entry once, then hands over to normal operation
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (state == S_INIT) begin
      ptr_nxt = ptr + AW'(1);
      if (ptr == LAST) state_nxt = S_RUN;
    end
  end

  // Storage has no reset; the sweep port owns the write mux until RUN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_INIT) mem[ptr] <= '0;
      else if (wr_ok)      mem[wa]  <= wd;
    end
  end

  // Scoreboard: writeback retires, issue sets; issue is last so it wins on a collision
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wa]       <= 1'b0;
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  // Combinational read ports, silenced during the sweep and for the hardwired zero
  always_comb begin
    rd1   = '0;
    rd2   = '0;
    busy1 = 1'b0;
    busy2 = 1'b0;
    if (run) begin
      if (!(ZERO_REG != 0 && ra1 == '0)) begin
        rd1   = mem[ra1];
        busy1 = busy[ra1];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_ok && wa == ra1) begin
          rd1 = wd;
          if (!(iss_ok && iss_addr == wa)) busy1 = 1'b0;
        end
`endif
      end
      if (!(ZERO_REG != 0 && ra2 == '0)) begin
        rd2   = mem[ra2];
        busy2 = busy[ra2];
`ifdef REG_FILE_SB_BYPASS_EN
        if (wr_ok && wa == ra2) begin
          rd2 = wd;
          if (!(iss_ok && iss_addr == wa)) busy2 = 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (default and DEPTH=8/WIDTH=16/ZERO_REG=0 instances)
module tb_reg_file_sb;

`ifdef REG_FILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0, iss_valid = 1'b0;
  logic [4:0]  wa = '0, ra1 = '0, ra2 = '0, iss_addr = '0;
  logic [31:0] wd = '0, rd1, rd2;
  logic        busy1, busy2, ready;

  logic        p_we = 1'b0, p_iss_valid = 1'b0;
  logic [2:0]  p_wa = '0, p_ra1 = '0, p_ra2 = '0, p_iss_addr = '0;
  logic [15:0] p_wd = '0, p_rd1, p_rd2;
  logic        p_busy1, p_busy2, p_ready;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .busy1(busy1), .busy2(busy2), .ready(ready)
  );

  reg_file_sb #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .we(p_we), .wa(p_wa), .wd(p_wd),
    .ra1(p_ra1), .ra2(p_ra2), .rd1(p_rd1), .rd2(p_rd2),
    .iss_valid(p_iss_valid), .iss_addr(p_iss_addr),
    .busy1(p_busy1), .busy2(p_busy2), .ready(p_ready)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ia;
    logic [4:0]  r1, r2;
    logic [31:0] e1, e2;
    logic        b1, b2;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[18];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic w, logic [4:0] a, logic [31:0] d, logic iv, logic [4:0] ia,
                              logic [4:0] r1, logic [4:0] r2, logic [31:0] e1, logic [31:0] e2,
                              logic b1, logic b2);
    vec_t v;
    v.we = w; v.wa = a; v.wd = d; v.iv = iv; v.ia = ia;
    v.r1 = r1; v.r2 = r2; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  function automatic logic [31:0] actual(int sel);
    case (sel)
      0: return rd1;
      1: return rd2;
      2: return {31'd0, busy1};
      3: return {31'd0, busy2};
      4: return {31'd0, ready};
      5: return {16'd0, p_rd1};
      6: return {16'd0, p_rd2};
      7: return {31'd0, p_busy1};
      default: return {31'd0, p_ready};
    endcase
  endfunction

  task automatic expect_val(string n, int sel, logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.exp = v;
    exp_q.push_back(e);
  endtask

  // Compare all pending expectations at the falling edge, away from the active edge
  task automatic drain();
    exp_t e;
    logic [31:0] a;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = actual(e.sel);
      n_cmp++;
      if (a !== e.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.exp, $time);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep(string n);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 20) begin
        we = 1'b0;
        iss_valid = 1'b0;
      end
      expect_val({n, "_ready"}, 4, {31'd0, k == 32});
      drain();
    end
  endtask

  initial begin
    tbl[0]  = mk(1,  7, 32'h12345678, 0,  0,  1, 0, 32'h0,        32'h0, 0, 0);
    tbl[1]  = mk(0,  0, 32'h0,        0,  0,  7, 0, 32'h12345678, 32'h0, 0, 0);
    tbl[2]  = mk(1,  0, 32'hFFFFFFFF, 0,  0,  7, 0, 32'h12345678, 32'h0, 0, 0);
    tbl[3]  = mk(0,  0, 32'h0,        0,  0,  0, 0, 32'h0,        32'h0, 0, 0);
    tbl[4]  = mk(0,  0, 32'h0,        1,  9,  9, 9, 32'h0,        32'h0, 0, 0);
    tbl[5]  = mk(0,  0, 32'h0,        0,  0,  9, 9, 32'h0,        32'h0, 1, 1);
    tbl[6]  = mk(0,  0, 32'h0,        1,  9,  9, 1, 32'h0,        32'h0, 1, 0);
    tbl[7]  = mk(1,  9, 32'hA5,       0,  0,  3, 7, 32'h0,        32'h12345678, 0, 0);
    tbl[8]  = mk(0,  0, 32'h0,        0,  0,  9, 9, 32'hA5,       32'hA5, 0, 0);
    tbl[9]  = mk(1,  9, 32'hB6,       1,  9, 10, 9, 32'h0,        BYP ? 32'hB6 : 32'hA5, 0, 0);
    tbl[10] = mk(0,  0, 32'h0,        0,  0,  9, 2, 32'hB6,       32'h0, 1, 0);
    tbl[11] = mk(0,  0, 32'h0,        1,  0,  0, 9, 32'h0,        32'hB6, 0, 1);
    tbl[12] = mk(1, 12, 32'hCAFE,     1, 13,  0, 9, 32'h0,        32'hB6, 0, 1);
    tbl[13] = mk(0,  0, 32'h0,        0,  0, 12, 13, 32'hCAFE,    32'h0, 0, 1);
    tbl[14] = mk(1, 13, 32'h1,        0,  0, 12, 0, 32'hCAFE,     32'h0, 0, 0);
    tbl[15] = mk(0,  0, 32'h0,        0,  0, 13, 12, 32'h1,       32'hCAFE, 0, 0);
    tbl[16] = mk(1,  4, 32'h11,       0,  0, 13, 12, 32'h1,       32'hCAFE, 0, 0);
    tbl[17] = mk(0,  0, 32'h0,        0,  0,  4, 0, 32'h11,       32'h0, 0, 0);

    // Reset held for 3 edges
    repeat (3) tick();
    expect_val("rst_ready", 4, 0);
    expect_val("rst_rd1", 0, 0);
    expect_val("rst_rd2", 1, 0);
    expect_val("rst_busy1", 2, 0);
    expect_val("rst_busy2", 3, 0);
    expect_val("rst_p_ready", 8, 0);
    drain();
    tick();

    // Release; writes and issues during the sweep must be ignored
    rst_n = 1'b1;
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    iss_valid = 1'b1; iss_addr = 5'd6;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 20) begin
        we = 1'b0;
        iss_valid = 1'b0;
      end
      expect_val("sweep_ready", 4, {31'd0, k == 32});
      if (k <= 9) expect_val("p_sweep_ready", 8, {31'd0, k >= 8});
      drain();
    end
    tick();

    // Every entry cleared and idle
    for (int a = 0; a < 32; a++) begin
      ra1 = 5'(a);
      ra2 = 5'(31 - a);
      expect_val("clr_rd1", 0, 0);
      expect_val("clr_rd2", 1, 0);
      expect_val("clr_busy1", 2, 0);
      expect_val("clr_busy2", 3, 0);
      drain();
      tick();
    end

    // Table-driven write/read/scoreboard vectors
    for (int i = 0; i < 18; i++) begin
      we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      iss_valid = tbl[i].iv; iss_addr = tbl[i].ia;
      ra1 = tbl[i].r1; ra2 = tbl[i].r2;
      expect_val($sformatf("v%0d_rd1", i), 0, tbl[i].e1);
      expect_val($sformatf("v%0d_rd2", i), 1, tbl[i].e2);
      expect_val($sformatf("v%0d_busy1", i), 2, {31'd0, tbl[i].b1});
      expect_val($sformatf("v%0d_busy2", i), 3, {31'd0, tbl[i].b2});
      drain();
      tick();
    end

    // Same-cycle write/read forwarding on x4 (holds 0x11)
    we = 1'b1; wa = 5'd4; wd = 32'h55; iss_valid = 1'b0; ra1 = 5'd4; ra2 = 5'd0;
    expect_val("byp_rd1", 0, BYP ? 32'h55 : 32'h11);
    expect_val("byp_busy1", 2, 0);
    drain(); tick();
    we = 1'b0; iss_valid = 1'b1; iss_addr = 5'd4;
    expect_val("byp_next_rd1", 0, 32'h55);
    drain(); tick();
    we = 1'b1; wd = 32'h66; iss_valid = 1'b0;
    expect_val("byp_busy_rd1", 0, BYP ? 32'h66 : 32'h55);
    expect_val("byp_busy_busy1", 2, BYP ? 32'h0 : 32'h1);
    drain(); tick();
    we = 1'b0;
    expect_val("byp_after_rd1", 0, 32'h66);
    expect_val("byp_after_busy1", 2, 0);
    drain(); tick();

    // Parametrised instance: entry 0 is ordinary
    p_we = 1'b1; p_wa = 3'd0; p_wd = 16'hBEEF;
    drain(); tick();
    p_we = 1'b0; p_ra1 = 3'd0; p_ra2 = 3'd0; p_iss_valid = 1'b1; p_iss_addr = 3'd0;
    expect_val("p_x0_rd1", 5, 32'hBEEF);
    expect_val("p_x0_rd2", 6, 32'hBEEF);
    drain(); tick();
    p_iss_valid = 1'b0;
    expect_val("p_x0_busy1", 7, 1);
    drain(); tick();

    // Reset mid-operation
    we = 1'b1; wa = 5'd3; wd = 32'h77; iss_valid = 1'b1; iss_addr = 5'd3; ra1 = 5'd3;
    expect_val("mid_pre_rd1", 0, BYP ? 32'h77 : 32'h0);
    expect_val("mid_pre_busy1", 2, 0);
    drain(); tick();
    we = 1'b0; iss_valid = 1'b0;
    expect_val("mid_x3_rd1", 0, 32'h77);
    expect_val("mid_x3_busy1", 2, 1);
    drain(); tick();
    rst_n = 1'b0;
    drain(); tick();
    rst_n = 1'b1;
    expect_val("mid_ready", 4, 0);
    expect_val("mid_busy1", 2, 0);
    expect_val("mid_rd1", 0, 0);
    drain();
    sweep("mid");
    tick();
    expect_val("mid_post_rd1", 0, 0);
    expect_val("mid_post_busy1", 2, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
